// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory path (multi-cycle responder
// and single-cycle memory alike).
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  // raw32 holds bytes addr..addr+3, so the addressed datum always sits in the low lanes
  function automatic logic [31:0] load_extend(input logic [31:0] raw32,
                                              input logic [1:0]  size,
                                              input logic        sign);
    case (size)
      SIZE_BYTE: return {{24{sign & raw32[7]}}, raw32[7:0]};
      SIZE_HALF: return {{16{sign & raw32[15]}}, raw32[15:0]};
      SIZE_WORD: return raw32;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return |addr_lo;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 4'b0001;
      SIZE_HALF: return 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-addressed little-endian storage: per-lane synchronous write, asynchronous
// 32-bit read of addr..addr+3.
module byte_ram #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr + ADDR_WIDTH'(i)] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      rdata[8*i +: 8] = mem[addr + ADDR_WIDTH'(i)];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, stores commit on
// acceptance, load data is read and extended when the response is registered.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  resp_state_t state, state_nxt;
  logic [3:0]  cnt;
  logic        reg_rsp;

  logic                  wr_p0;
  logic                  sign_p0;
  logic [1:0]            size_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;

  logic                  cur_wr;
  logic                  cur_sign;
  logic [1:0]            cur_size;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_err;
  logic [3:0]            ram_we;
  logic [31:0]           ram_rdata;
  logic [31:0]           rdata_nxt;

  // upper address bits alias onto the array
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  // While idle the live request is the one being served; afterwards the latched copy
  always_comb begin
    if (state == IDLE) begin
      cur_wr   = req_write;
      cur_sign = req_sign;
      cur_size = req_size;
      cur_addr = req_addr[ADDR_WIDTH-1:0];
    end else begin
      cur_wr   = wr_p0;
      cur_sign = sign_p0;
      cur_size = size_p0;
      cur_addr = addr_p0;
    end
  end

  assign cur_err   = access_err(cur_size, cur_addr[1:0]);
  assign ram_we    = (rst && req_valid && req_ready && req_write && !cur_err)
                     ? byte_mask(req_size) : 4'b0000;
  assign rdata_nxt = (cur_wr || cur_err) ? 32'h0 : load_extend(ram_rdata, cur_size, cur_sign);

  byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_addr),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    reg_rsp   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            reg_rsp   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          reg_rsp   = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (state == IDLE && req_valid) begin
      cnt <= CNT_LOAD;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // request capture stage
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      wr_p0   <= req_write;
      sign_p0 <= req_sign;
      size_p0 <= req_size;
      addr_p0 <= req_addr[ADDR_WIDTH-1:0];
    end
  end

  // response stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (reg_rsp) begin
      rsp_rdata <= rdata_nxt;
      rsp_err   <= cur_err;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=1,
// sharing request inputs and selected through sel.
module tb_dmem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic        sel;

  logic        ready2, valid2, err2, ready1, valid1, err1;
  logic [31:0] rdata2, rdata1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(ready2),
    .req_write(req_write), .req_size(req_size), .req_sign(req_sign),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid2),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata2), .rsp_err(err2)
  );

  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(ready1),
    .req_write(req_write), .req_size(req_size), .req_sign(req_sign),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid1),
    .rsp_ready(rsp_ready), .rsp_rdata(rdata1), .rsp_err(err1)
  );

  assign req_ready = sel ? ready1 : ready2;
  assign rsp_valid = sel ? valid1 : valid2;
  assign rsp_rdata = sel ? rdata1 : rdata2;
  assign rsp_err   = sel ? err1   : err2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge with
  // the request inputs scrambled so late changes would be visible.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    logic seen;
    logic accepted;
    accepted  = 1'b0;
    req_write = w;
    req_size  = sz;
    req_sign  = sg;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      seen = req_ready;
      @(posedge clk);
      if (seen) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_size  = 2'($urandom);
    req_sign  = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic collect(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int exp_idx;
    n       = 1;
    exp_idx = sel ? 1 : 3;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_idx));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_drop"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic seen_valid;
    int   n;
    sel = 1'b0;
    rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = SIZE_WORD;
    req_sign  = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'h0);
      check("rst_err",   {31'b0, rsp_err}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, req_ready}, 32'd1);

    issue(1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hDEADBEEF); collect("st_w100", 32'h0, 1'b0);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);        collect("ld_w100", 32'hDEADBEEF, 1'b0);
    issue(1'b0, SIZE_BYTE, 1'b1, 32'h103, 32'h0);        collect("ld_b103s", 32'hFFFFFFDE, 1'b0);
    issue(1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0);        collect("ld_b103u", 32'h000000DE, 1'b0);

    issue(1'b1, SIZE_WORD, 1'b0, 32'h200, 32'h0);        collect("st_w200", 32'h0, 1'b0);
    issue(1'b1, SIZE_HALF, 1'b1, 32'h202, 32'h12348001); collect("st_h202", 32'h0, 1'b0);
    issue(1'b0, SIZE_WORD, 1'b1, 32'h200, 32'h0);        collect("ld_w200", 32'h80010000, 1'b0);
    issue(1'b0, SIZE_HALF, 1'b1, 32'h202, 32'h0);        collect("ld_h202s", 32'hFFFF8001, 1'b0);
    issue(1'b0, SIZE_HALF, 1'b0, 32'h202, 32'h0);        collect("ld_h202u", 32'h00008001, 1'b0);

    issue(1'b1, SIZE_WORD, 1'b0, 32'h104, 32'h55667788); collect("st_w104", 32'h0, 1'b0);
    issue(1'b1, SIZE_WORD, 1'b0, 32'h105, 32'h11111111); collect("st_w105_mis", 32'h0, 1'b1);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h104, 32'h0);        collect("ld_w104", 32'h55667788, 1'b0);
    issue(1'b0, 2'b11,     1'b0, 32'h104, 32'h0);        collect("ld_rsvd", 32'h0, 1'b1);
    issue(1'b1, SIZE_HALF, 1'b0, 32'h101, 32'h00007777); collect("st_h101_mis", 32'h0, 1'b1);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h102, 32'h0);        collect("ld_w102_mis", 32'h0, 1'b1);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);        collect("ld_w100_keep", 32'hDEADBEEF, 1'b0);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h10100, 32'h0);      collect("ld_alias", 32'hDEADBEEF, 1'b0);

    // backpressure with a second request waiting
    issue(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_lat", 32'(n), 32'd3);
    req_write = 1'b0;
    req_size  = SIZE_WORD;
    req_sign  = 1'b0;
    req_addr  = 32'h200;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_drop", {31'b0, rsp_valid}, 32'd0);
    check("bp_ready_after", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    collect("bp_next", 32'h80010000, 1'b0);

    // reset while waiting
    issue(1'b1, SIZE_WORD, 1'b0, 32'h300, 32'hCAFEF00D);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen_valid |= rsp_valid;
      @(negedge clk);
    end
    check("rstw_novalid", {31'b0, seen_valid}, 32'd0);
    check("rstw_ready", {31'b0, req_ready}, 32'd1);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h300, 32'h0);        collect("ld_w300", 32'hCAFEF00D, 1'b0);

    sel = 1'b1;
    @(negedge clk);
    issue(1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h89ABCDEF);  collect("l1_st_w40", 32'h0, 1'b0);
    issue(1'b0, SIZE_BYTE, 1'b1, 32'h41, 32'h0);         collect("l1_ld_b41s", 32'hFFFFFFCD, 1'b0);
    issue(1'b0, SIZE_HALF, 1'b0, 32'h42, 32'h0);         collect("l1_ld_h42u", 32'h000089AB, 1'b0);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0);         collect("l1_ld_w40", 32'h89ABCDEF, 1'b0);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h43, 32'h0);         collect("l1_ld_mis", 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
